// File: rtl/light_phase_timer_if.sv
// rtl/light_phase_timer_if.sv - lamp, pedestrian and timer status signals between sequencer side and light_phase_timer
interface light_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             red_in;
    logic             yellow_in;
    logic             green_in;
    logic             ped_req;
    logic             advance;
    logic             ped_walk;
    logic             ped_pending;
    logic [CNT_W-1:0] remaining;
    logic             fault;

    // Sequencer / environment side: drives lamps and requests, observes the timer
    modport master (
        output red_in, yellow_in, green_in, ped_req,
        input  advance, ped_walk, ped_pending, remaining, fault
    );

    // Timer side
    modport slave (
        input  red_in, yellow_in, green_in, ped_req,
        output advance, ped_walk, ped_pending, remaining, fault
    );
endinterface

// File: rtl/light_phase_timer.sv
// rtl/light_phase_timer.sv - phase dwell timer issuing advance strobes to the lamp sequencer
module light_phase_timer #(
    parameter int PRESCALE        = 1000,
    parameter int RED_TICKS       = 30,
    parameter int GREEN_TICKS     = 25,
    parameter int YELLOW_TICKS    = 5,
    parameter int PED_EXTRA_TICKS = 10,
    parameter int ADV_TIMEOUT     = 4,
    parameter int CNT_W           = 8
) (
    input logic                clk,
    input logic                reset,
    light_phase_timer_if.slave bus
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam int WT_W = $clog2(ADV_TIMEOUT + 1);

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [WT_W-1:0]  WT_LAST   = WT_W'(ADV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RED_L     = CNT_W'(RED_TICKS);
    localparam logic [CNT_W-1:0] GREEN_L   = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_L  = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] RED_PED_L = CNT_W'(RED_TICKS + PED_EXTRA_TICKS);

    typedef enum logic [1:0] {S_LOAD, S_TIMING, S_ADV_WAIT, S_FAULT} state_t;
    typedef enum logic [1:0] {PH_RED, PH_GREEN, PH_YELLOW} phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [WT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             advance_q, advance_d;
    logic             ped_walk_q, ped_walk_d;
    logic             ped_pending_q, ped_pending_d;
    logic             fault_q, fault_d;

    logic   lamp_valid;
    phase_t lamp_phase;
    logic   ped_clr;
    logic   go_fault;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:   return PH_GREEN;
            PH_GREEN: return PH_YELLOW;
            default:  return PH_RED;
        endcase
    endfunction

    // Decode the one-hot lamp pattern; anything else is an illegal pattern
    always_comb begin
        lamp_valid = 1'b0;
        lamp_phase = PH_RED;
        case ({bus.red_in, bus.yellow_in, bus.green_in})
            3'b100: begin lamp_valid = 1'b1; lamp_phase = PH_RED;    end
            3'b010: begin lamp_valid = 1'b1; lamp_phase = PH_YELLOW; end
            3'b001: begin lamp_valid = 1'b1; lamp_phase = PH_GREEN;  end
            default: begin lamp_valid = 1'b0; lamp_phase = PH_RED;   end
        endcase
    end

    // Next-state and output logic for the load/time/advance/fault sequence
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        presc_d     = presc_q;
        wait_d      = wait_q;
        remaining_d = remaining_q;
        advance_d   = 1'b0;
        ped_walk_d  = ped_walk_q;
        fault_d     = fault_q;
        ped_clr     = 1'b0;
        go_fault    = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (!lamp_valid) begin
                    go_fault = 1'b1;
                end else begin
                    phase_d = lamp_phase;
                    presc_d = '0;
                    state_d = S_TIMING;
                    case (lamp_phase)
                        PH_RED: begin
                            if (ped_pending_q) begin
                                remaining_d = RED_PED_L;
                                ped_walk_d  = 1'b1;
                                ped_clr     = 1'b1;
                            end else begin
                                remaining_d = RED_L;
                            end
                        end
                        PH_GREEN: remaining_d = GREEN_L;
                        default:  remaining_d = YELLOW_L;
                    endcase
                end
            end
            S_TIMING: begin
                if (!lamp_valid || (lamp_phase != phase_q)) begin
                    go_fault = 1'b1;
                end else if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    if (remaining_q <= CNT_W'(1)) begin
                        // Final tick: strobe the sequencer and watch for its response
                        remaining_d = '0;
                        advance_d   = 1'b1;
                        wait_d      = '0;
                        state_d     = S_ADV_WAIT;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end
            S_ADV_WAIT: begin
                if (!lamp_valid) begin
                    go_fault = 1'b1;
                end else if (lamp_phase == next_phase(phase_q)) begin
                    ped_walk_d = 1'b0;
                    state_d    = S_LOAD;
                end else if (lamp_phase == phase_q) begin
                    if (wait_q == WT_LAST) begin
                        go_fault = 1'b1;
                    end else begin
                        wait_d = wait_q + WT_W'(1);
                    end
                end else begin
                    go_fault = 1'b1;
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (go_fault) begin
            state_d     = S_FAULT;
            fault_d     = 1'b1;
            ped_walk_d  = 1'b0;
            remaining_d = '0;
            advance_d   = 1'b0;
        end

        // A new request wins over the clear issued by a serving red load
        ped_pending_d = bus.ped_req | (ped_pending_q & ~ped_clr);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_LOAD;
            phase_q       <= PH_RED;
            presc_q       <= '0;
            wait_q        <= '0;
            remaining_q   <= '0;
            advance_q     <= 1'b0;
            ped_walk_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            presc_q       <= presc_d;
            wait_q        <= wait_d;
            remaining_q   <= remaining_d;
            advance_q     <= advance_d;
            ped_walk_q    <= ped_walk_d;
            ped_pending_q <= ped_pending_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.advance     = advance_q;
    assign bus.ped_walk    = ped_walk_q;
    assign bus.ped_pending = ped_pending_q;
    assign bus.remaining   = remaining_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_light_phase_timer.sv
// tb/tb_light_phase_timer.sv - scoreboard bench for light_phase_timer with a model lamp sequencer
module tb_light_phase_timer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    light_phase_timer_if #(.CNT_W(8)) bus ();

    light_phase_timer #(
        .PRESCALE(4), .RED_TICKS(3), .GREEN_TICKS(2), .YELLOW_TICKS(1),
        .PED_EXTRA_TICKS(2), .ADV_TIMEOUT(4), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    typedef struct {
        int   gap;
        logic walk;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   cyc      = 0;
    int   adv_seen = 0;

    logic [2:0] seq_lamps;
    logic [2:0] force_pat;
    logic       force_en;
    logic       ignore_adv;
    logic       ped_req_drv;

    assign {bus.red_in, bus.yellow_in, bus.green_in} = force_en ? force_pat : seq_lamps;
    assign bus.ped_req = ped_req_drv;

    // Free-running cycle count used to measure dwell gaps
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int gap, input logic walk);
        exp_t e;
        e.gap  = gap;
        e.walk = walk;
        exp_q.push_back(e);
    endtask

    task automatic wait_adv(input int n);
        for (int i = 0; i < 400 && adv_seen < n; i++) step();
        check("advance_count", adv_seen, n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_advance"},     int'(bus.advance),     0);
        check({tag, "_ped_walk"},    int'(bus.ped_walk),    0);
        check({tag, "_ped_pending"}, int'(bus.ped_pending), 0);
        check({tag, "_fault"},       int'(bus.fault),       0);
        check({tag, "_remaining"},   int'(bus.remaining),   0);
    endtask

    task automatic do_reset(input string tag);
        step();
        reset = 1'b1;
        #1;
        check_idle(tag);
        ignore_adv  = 1'b0;
        force_en    = 1'b0;
        ped_req_drv = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Model lamp sequencer: steps one clock after seeing the advance strobe
    initial begin
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seq_lamps = L_RED;
                pend      = 1'b0;
            end else begin
                if (pend) begin
                    case (seq_lamps)
                        L_RED:   seq_lamps = L_GRN;
                        L_GRN:   seq_lamps = L_YEL;
                        default: seq_lamps = L_RED;
                    endcase
                    pend = 1'b0;
                end
                if (bus.advance && !ignore_adv) pend = 1'b1;
            end
        end
    end

    // Monitor: every advance strobe is matched against the next expected dwell
    initial begin
        int   ref_cyc;
        exp_t e;
        ref_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ref_cyc = cyc;
            end else if (bus.advance) begin
                adv_seen++;
                if (exp_q.size() == 0) begin
                    check($sformatf("adv%0d_unexpected", adv_seen), int'(bus.advance), 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("adv%0d_gap", adv_seen), cyc - ref_cyc, e.gap);
                    check($sformatf("adv%0d_walk", adv_seen), int'(bus.ped_walk), int'(e.walk));
                    check($sformatf("adv%0d_remaining", adv_seen), int'(bus.remaining), 0);
                end
                ref_cyc = cyc;
            end
        end
    end

    // Directed stimulus
    initial begin
        reset       = 1'b1;
        ped_req_drv = 1'b0;
        force_en    = 1'b0;
        force_pat   = 3'b000;
        ignore_adv  = 1'b0;
        step();
        step();
        step();
        check_idle("reset");
        reset = 1'b0;

        // Normal cycle, pedestrian pulse, request held over a red load, then ignored advance
        push(13, 1'b0); push(11, 1'b0); push(7, 1'b0); push(15, 1'b0);
        push(11, 1'b0); push(7, 1'b0);  push(23, 1'b1);
        push(11, 1'b0); push(7, 1'b0);  push(23, 1'b1);
        push(11, 1'b0); push(7, 1'b0);  push(23, 1'b1);
        push(11, 1'b0);

        step();
        check("first_remaining", int'(bus.remaining), 3);
        repeat (4) step();
        check("after_tick_remaining", int'(bus.remaining), 2);

        wait_adv(4);
        check("cycle_fault", int'(bus.fault), 0);

        repeat (5) step();
        ped_req_drv = 1'b1;
        step();
        ped_req_drv = 1'b0;
        check("green_ped_pending", int'(bus.ped_pending), 1);
        check("green_ped_walk", int'(bus.ped_walk), 0);

        wait_adv(6);
        repeat (3) step();
        check("ped_red_walk", int'(bus.ped_walk), 1);
        check("ped_red_pending", int'(bus.ped_pending), 0);
        check("ped_red_remaining", int'(bus.remaining), 5);

        wait_adv(7);
        step();
        check("walk_until_green", int'(bus.ped_walk), 1);
        step();
        check("walk_drop", int'(bus.ped_walk), 0);

        wait_adv(9);
        step();
        ped_req_drv = 1'b1;
        step();
        step();
        check("held_req_walk", int'(bus.ped_walk), 1);
        check("held_req_pending", int'(bus.ped_pending), 1);
        ped_req_drv = 1'b0;
        step();
        check("held_req_pending_kept", int'(bus.ped_pending), 1);

        wait_adv(13);
        step();
        step();
        ignore_adv = 1'b1;
        wait_adv(14);
        repeat (3) step();
        check("timeout_fault_early", int'(bus.fault), 0);
        step();
        check("timeout_fault", int'(bus.fault), 1);
        check("timeout_pending_before", int'(bus.ped_pending), 0);
        ped_req_drv = 1'b1;
        step();
        ped_req_drv = 1'b0;
        check("fault_ped_latched", int'(bus.ped_pending), 1);
        repeat (20) step();
        check("fault_sticky", int'(bus.fault), 1);
        check("fault_advance", int'(bus.advance), 0);
        check("fault_remaining", int'(bus.remaining), 0);
        check("fault_walk", int'(bus.ped_walk), 0);

        // Illegal pattern mid-timing
        do_reset("rst_a");
        repeat (5) step();
        check("illegal_pre_fault", int'(bus.fault), 0);
        force_pat = 3'b101;
        force_en  = 1'b1;
        step();
        check("illegal_fault", int'(bus.fault), 1);
        check("illegal_remaining", int'(bus.remaining), 0);

        // Red followed by yellow
        do_reset("rst_b");
        ignore_adv = 1'b1;
        push(13, 1'b0);
        wait_adv(15);
        step();
        check("order_pre_fault", int'(bus.fault), 0);
        force_pat = L_YEL;
        force_en  = 1'b1;
        step();
        check("order_fault", int'(bus.fault), 1);

        // Reset mid-phase with a pending request
        do_reset("rst_c");
        step();
        ped_req_drv = 1'b1;
        step();
        ped_req_drv = 1'b0;
        repeat (4) step();
        check("midphase_remaining", int'(bus.remaining), 2);
        check("midphase_pending", int'(bus.ped_pending), 1);
        do_reset("rst_mid");
        push(13, 1'b0);
        push(11, 1'b0);
        step();
        check("fresh_remaining", int'(bus.remaining), 3);
        wait_adv(17);
        check("fresh_fault", int'(bus.fault), 0);
        check("fresh_pending", int'(bus.ped_pending), 0);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
